led_seq_ctrl: RTL
=================

// Module: led_seq_ctrl
// PURPOSE
//   Sequencer and brightness controller for the 8-bit LED output bank (uo_out).
//   Steps a selectable pattern at a programmable tick rate and gates it with a
//   PWM duty mask. Top-level pins drive it; tt_um_* wires led_out to uo_out.
// PARAMETERS
//   N_LEDS   8      LED count; pattern width
//   DIV      50000  clk cycles per pattern tick (>= 2)
//   PWM_W    4      PWM counter/duty width
// PORTS
//   clk        in   1       system clock
//   rst        in   1       synchronous reset, active-high
//   cfg_valid  in   1       config offer; hold until cfg_ready
//   cfg_ready  out  1       config accepted this cycle when cfg_valid&cfg_ready
//   cfg_mode   in   2       0 off, 1 walk, 2 bounce, 3 blink
//   cfg_duty   in   PWM_W   brightness; 0 = dark, LED lit while pwm_cnt < duty
//   start      in   1       pulse: IDLE -> RUN
//   stop       in   1       pulse: RUN -> IDLE
//   led_out    out  N_LEDS  registered LED drive
//   busy       out  1       1 while in RUN
//   tick       out  1       1-cycle pulse when pattern advances (RUN only)
// BEHAVIOUR
//   Reset: state IDLE, mode=0, duty={PWM_W{1}}, pattern=0, led_out=0, busy=0,
//     tick=0, prescaler=0, pwm_cnt=0. Reset mid-RUN aborts at the next edge.
//   FSM IDLE: cfg_ready=1 (combinational); led_out=0. start -> RUN.
//   FSM RUN: busy=1. stop -> IDLE next edge; pattern cleared, led_out=0 next edge.
//     start&stop same cycle: stop wins (in either state).
//   Entering RUN: prescaler cleared; pattern loaded with mode's initial value,
//     visible on led_out the cycle after start (subject to PWM mask).
//   Config in IDLE: accepted the cycle it is offered; start in the same cycle
//     uses the new mode/duty.
//   Config in RUN: cfg_ready=1 only in a cycle where tick=1 AND pattern is at its
//     period boundary; the accepting tick loads the new mode's initial pattern
//     instead of advancing. Otherwise cfg_valid waits.
//   Prescaler: 0..DIV-1, wraps; tick=1 when prescaler==DIV-1 in RUN.
//   Patterns (initial value; step on tick; boundary = last state of period):
//     off    0; stays 0; every tick is a boundary.
//     walk   0x01; rotate left, bit N-1 -> bit 0; boundary at 0x80 (N=8).
//     bounce 0x01, dir up; shift by dir; dir flips on reaching bit N-1 or bit 0;
//            period 2N-2 ticks; boundary at bit 1 moving down.
//     blink  all ones; toggle all/none; boundary at none.
//   PWM: pwm_cnt PWM_W-bit free-running every clk, wraps 2^PWM_W-1 -> 0.
//     led_out <= busy_next ? pattern_next & {N{pwm_cnt < duty}} : 0.
//     duty=0 -> always dark; duty=15 -> lit 15 of 16 cycles.
//   All outputs except cfg_ready are registered.
// STRUCTURE
//   led_seq_pkg: mode enum (MODE_OFF/WALK/BOUNCE/BLINK), state enum (IDLE/RUN),
//     pattern-initial-value function.
//   Sub-module led_tick_gen (prescaler; ports clk, rst, clr, en, tick).
//   Pattern, FSM and PWM gating stay in led_seq_ctrl.
// TESTING (DIV=4, PWM_W=4, N_LEDS=8 for sim)
//   1 Reset: rst high 2 cycles -> led_out=0, busy=0, cfg_ready=1, tick never.
//   2 cfg mode=1 duty=15 + start: every 4 clks pattern 01,02,..,80,01;
//     led_out equals pattern except when pwm_cnt=15 (0).
//   3 Bounce: seq 01,02,..,80,40,..,02,01, period 14 ticks; in RUN hold
//     cfg_valid mode=3 -> cfg_ready only on tick at boundary (02 moving down),
//     next led pattern FF.
//   4 duty=0 in walk -> led_out=0 always while busy=1; duty=8 -> lit 8/16.
//   5 start&stop same cycle in IDLE -> stays IDLE; stop mid-RUN -> led_out=0,
//     busy=0 next edge; restart reloads 01 with prescaler cleared.
//   6 rst asserted mid-RUN at pattern 10 -> next edge led_out=0, mode=off, duty=15.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED sequencer: pattern modes, FSM
// states and the per-mode initial pattern value.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Widest LED bank the helper below can describe; callers keep the low bits.
    localparam int PAT_MAX_W = 32;

    // First pattern shown after entering RUN or after a mode change on a tick.
    function automatic logic [PAT_MAX_W-1:0] pattern_init(input mode_e mode,
                                                          input int unsigned width);
        logic [PAT_MAX_W-1:0] ones;
        ones = {PAT_MAX_W{1'b1}} >> (PAT_MAX_W - width);
        case (mode)
            MODE_OFF:                return '0;
            MODE_WALK, MODE_BOUNCE:  return PAT_MAX_W'(1);
            default:                 return ones;
        endcase
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Pattern-rate prescaler: counts 0..DIV-1 while enabled and raises a
// registered one-cycle tick during the cycle the count sits at DIV-1.
module led_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_next;

    // Next count: clear wins, otherwise wrap at DIV-1 while enabled.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        cnt_next = cnt_q;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Count register and tick flag, tick aligned with the count reaching DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
            cnt_q <= cnt_next;
            tick  <= en && !clr && (cnt_next == LAST);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: steps a selectable pattern at the prescaler tick rate,
// takes configuration through a valid/ready handshake and gates the pattern
// with a free-running PWM duty mask.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int N_LEDS = 8,
    parameter int DIV    = 50000,
    parameter int PWM_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_mode,
    input  logic [PWM_W-1:0]  cfg_duty,
    input  logic              start,
    input  logic              stop,
    output logic [N_LEDS-1:0] led_out,
    output logic              busy,
    output logic              tick
);

    // Bounce period ends on bit 1 while travelling down.
    localparam logic [N_LEDS-1:0] BOUNCE_LAST = N_LEDS'(2);

    state_e             state_q;
    mode_e              mode_q;
    mode_e              mode_next;
    logic [PWM_W-1:0]   duty_q;
    logic [PWM_W-1:0]   duty_next;
    logic [N_LEDS-1:0]  pattern_q;
    logic [N_LEDS-1:0]  pattern_next;
    logic               dir_down_q;
    logic               dir_down_next;
    logic [PWM_W-1:0]   pwm_cnt_q;
    logic               at_boundary;
    logic               cfg_accept;
    logic               enter_run;
    logic               run_next;
    logic               tick_clr;
    logic [PAT_MAX_W-1:0] init_wide;
    logic [N_LEDS-1:0]  init_pat;
    logic [N_LEDS-1:0]  led_next;

    // Period boundary of the current pattern: config may only land here in RUN.
    always_comb begin
        at_boundary = 1'b0;
        case (mode_q)
            MODE_OFF:    at_boundary = 1'b1;
            MODE_WALK:   at_boundary = pattern_q[N_LEDS-1];
            MODE_BOUNCE: at_boundary = dir_down_q && (pattern_q == BOUNCE_LAST);
            default:     at_boundary = (pattern_q == '0);
        endcase
    end

    assign cfg_ready  = (state_q == IDLE) || (tick && at_boundary);
    assign cfg_accept = cfg_valid && cfg_ready;
    assign mode_next  = cfg_accept ? mode_e'(cfg_mode) : mode_q;
    assign duty_next  = cfg_accept ? cfg_duty : duty_q;

    // Stop beats start in both states.
    assign enter_run  = (state_q == IDLE) && start && !stop;
    assign run_next   = !stop && ((state_q == RUN) || start);
    assign tick_clr   = !run_next || enter_run;

    assign init_wide  = pattern_init(mode_next, unsigned'(N_LEDS));
    assign init_pat   = init_wide[N_LEDS-1:0];

    // Next pattern: clear on leaving RUN, reload on entry or on a config tick, else step.
    always_comb begin
        pattern_next  = pattern_q;
        dir_down_next = dir_down_q;
        if (!run_next) begin
            pattern_next  = '0;
            dir_down_next = 1'b0;
        end else if (enter_run || (tick && cfg_accept)) begin
            pattern_next  = init_pat;
            dir_down_next = 1'b0;
        end else if (tick) begin
            case (mode_q)
                MODE_OFF: pattern_next = '0;
                MODE_WALK: pattern_next = {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};
                MODE_BOUNCE: begin
                    if (!dir_down_q) begin
                        pattern_next  = pattern_q << 1;
                        dir_down_next = pattern_next[N_LEDS-1];
                    end else begin
                        pattern_next  = pattern_q >> 1;
                        dir_down_next = !pattern_next[0];
                    end
                end
                default: pattern_next = ~pattern_q;
            endcase
        end
    end

    assign led_next = run_next ? (pattern_next & {N_LEDS{pwm_cnt_q < duty_next}}) : '0;

    // FSM, configuration, pattern, PWM counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= MODE_OFF;
            duty_q     <= '1;
            pattern_q  <= '0;
            dir_down_q <= 1'b0;
            pwm_cnt_q  <= '0;
            led_out    <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= run_next ? RUN : IDLE;
            mode_q     <= mode_next;
            duty_q     <= duty_next;
            pattern_q  <= pattern_next;
            dir_down_q <= dir_down_next;
            pwm_cnt_q  <= pwm_cnt_q + PWM_W'(1);
            led_out    <= led_next;
            busy       <= run_next;
        end
    end

    led_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .en   (run_next),
        .tick (tick)
    );

endmodule
